// File: rtl/spi_stream_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_stream_ctrl_pkg
// Shared definitions for the SPI byte-stream front end: the byte width used on
// every data path and the state encoding of the launch/capture controller.
// -----------------------------------------------------------------------------
package spi_stream_ctrl_pkg;

   localparam int BYTE_W = 8;

   // IDLE    : waiting for a TX byte and a free RX slot
   // WAIT_HI : START issued, waiting for the master to raise BUSY
   // WAIT_LO : transfer in flight, waiting for BUSY to fall
   // GAP     : one dead cycle so the master can deassert CS between bytes
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_HI = 2'd1,
      ST_WAIT_LO = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

endpackage : spi_stream_ctrl_pkg

// File: rtl/sync_fifo_m.sv
// -----------------------------------------------------------------------------
// sync_fifo_m
// Single-clock byte FIFO with first-word fall-through head and occupancy count.
//
// Ports:
//   i_clk    : clock
//   i_rst    : asynchronous, active-high reset (empties the FIFO)
//   i_wr     : push i_wdata; ignored when full
//   i_wdata  : byte to push
//   i_rd     : pop the head; ignored when empty
//   o_rdata  : current head (valid when o_empty = 0)
//   o_empty  : FIFO empty
//   o_level  : number of stored entries, 0..DEPTH
// Fullness is o_level == DEPTH; callers decode it from the level.
// -----------------------------------------------------------------------------
module sync_fifo_m
   import spi_stream_ctrl_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr,
   input  logic [BYTE_W-1:0] i_wdata,
   input  logic              i_rd,
   output logic [BYTE_W-1:0] o_rdata,
   output logic              o_empty,
   output logic [AW:0]       o_level
);

   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

   logic [BYTE_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;

   logic              w_full;
   logic              w_do_wr;
   logic              w_do_rd;

   assign w_full  = (r_count == L_DEPTH);
   assign o_empty = (r_count == '0);
   assign o_level = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   // Gating each side on its own flag gives the corner cases for free:
   // empty+rd+wr accepts only the write, full+rd+wr accepts only the read.
   assign w_do_wr = i_wr & ~w_full;
   assign w_do_rd = i_rd & ~o_empty;

   // NOTE: storage has no reset; the pointers and count define validity, and
   // leaving the array out of reset lets it map onto plain RAM/flops.
   always_ff @(posedge i_clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // NOTE: sequential state is always assigned with <= so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Pointers are AW bits wide, so DEPTH being a power of two makes
         // the increment wrap modulo DEPTH.
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : sync_fifo_m

// File: rtl/spi_stream_ctrl.sv
// -----------------------------------------------------------------------------
// spi_stream_ctrl
// Byte-stream front end for spi_master_m. Host bytes are queued in a TX FIFO
// and launched one per SPI transfer (one-cycle START, DOUT held until the next
// launch); the master's DIN is captured when BUSY falls and queued in an RX
// FIFO. A launch only happens when RX has a free slot, so RX never overflows.
//
// Ports:
//   i_clk       : system clock, shared with spi_master_m
//   i_rst       : asynchronous, active-high reset
//   i_tx_data   : byte to transmit
//   i_tx_wr     : push i_tx_data (ignored when o_tx_full)
//   o_tx_full   : TX FIFO full
//   o_tx_level  : TX FIFO occupancy
//   o_rx_data   : RX FIFO head, first-word fall-through
//   i_rx_rd     : pop RX head (ignored when o_rx_empty)
//   o_rx_empty  : RX FIFO empty
//   o_tx_drop   : one-cycle pulse for a TX write rejected because full
//   o_m_start   : START to spi_master_m
//   i_m_busy    : BUSY from spi_master_m
//   o_m_dout    : DOUT to spi_master_m
//   i_m_din     : DIN from spi_master_m
// -----------------------------------------------------------------------------
module spi_stream_ctrl
   import spi_stream_ctrl_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [BYTE_W-1:0] i_tx_data,
   input  logic              i_tx_wr,
   output logic              o_tx_full,
   output logic [AW:0]       o_tx_level,
   output logic [BYTE_W-1:0] o_rx_data,
   input  logic              i_rx_rd,
   output logic              o_rx_empty,
   output logic              o_tx_drop,
   output logic              o_m_start,
   input  logic              i_m_busy,
   output logic [BYTE_W-1:0] o_m_dout,
   input  logic [BYTE_W-1:0] i_m_din
);

   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

   state_t            r_state;
   logic              r_m_start;
   logic [BYTE_W-1:0] r_m_dout;
   logic              r_tx_drop;

   logic [BYTE_W-1:0] w_tx_head;
   logic              w_tx_empty;
   logic [AW:0]       w_tx_level;
   logic              w_rx_empty;
   logic [AW:0]       w_rx_level;
   logic              w_launch;
   logic              w_rx_push;

   // Launch pops the TX head in the same cycle START is registered, so the
   // byte on o_m_dout and the FIFO pop stay in lockstep.
   assign w_launch  = (r_state == ST_IDLE) & ~w_tx_empty & (w_rx_level != L_DEPTH);

   // DIN is pushed on the same edge that first samples BUSY low.
   assign w_rx_push = (r_state == ST_WAIT_LO) & ~i_m_busy;

   sync_fifo_m #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_tx_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wr    (i_tx_wr),
      .i_wdata (i_tx_data),
      .i_rd    (w_launch),
      .o_rdata (w_tx_head),
      .o_empty (w_tx_empty),
      .o_level (w_tx_level)
   );

   sync_fifo_m #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_rx_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wr    (w_rx_push),
      .i_wdata (i_m_din),
      .i_rd    (i_rx_rd),
      .o_rdata (o_rx_data),
      .o_empty (w_rx_empty),
      .o_level (w_rx_level)
   );

   assign o_tx_full  = (w_tx_level == L_DEPTH);
   assign o_tx_level = w_tx_level;
   assign o_rx_empty = w_rx_empty;
   assign o_m_start  = r_m_start;
   assign o_m_dout   = r_m_dout;
   assign o_tx_drop  = r_tx_drop;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx_drop <= 1'b0;
      end else begin
         // A write presented while full is rejected, even if the controller
         // pops in the same cycle.
         r_tx_drop <= i_tx_wr & o_tx_full;
      end
   end

   // Reset returns to IDLE from any state; an abandoned transfer's DIN is
   // never captured because only WAIT_LO pushes into RX.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_m_start <= 1'b0;
         r_m_dout  <= '0;
      end else begin
         r_m_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_launch) begin
                  r_m_dout  <= w_tx_head;
                  r_m_start <= 1'b1;
                  r_state   <= ST_WAIT_HI;
               end
            end
            ST_WAIT_HI: begin
               if (i_m_busy) r_state <= ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
               if (!i_m_busy) r_state <= ST_GAP;
            end
            ST_GAP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : spi_stream_ctrl

// File: tb/tb_spi_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_stream_ctrl
// Drives spi_stream_ctrl against a behavioural SPI master model. The model
// raises BUSY the cycle after it sees START, holds it BUSY_CYC cycles (or
// indefinitely while hold_busy is set) and returns DIN = ~DOUT of the byte it
// sent. Expected MOSI bytes and RX bytes are queued when TX bytes are driven.
// -----------------------------------------------------------------------------
module tb_spi_stream_ctrl;

   localparam int DEPTH    = 8;
   localparam int AW       = 3;
   localparam int BUSY_CYC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    tx_data;
   logic          tx_wr;
   logic          tx_full;
   logic [AW:0]   tx_level;
   logic [7:0]    rx_data;
   logic          rx_rd;
   logic          rx_empty;
   logic          tx_drop;
   logic          m_start;
   logic          m_busy = 1'b0;
   logic [7:0]    m_dout;
   logic [7:0]    m_din  = 8'h00;

   int            total = 0;
   int            bad   = 0;

   logic [7:0]    exp_mosi [$];
   logic [7:0]    exp_rx   [$];

   int            start_cnt  = 0;
   int            busy_cnt   = 0;
   bit            hold_busy  = 1'b0;
   bit            mon_en     = 1'b1;
   logic [7:0]    cur_dout   = 8'h00;
   logic [7:0]    e_mosi;
   logic          prev_start = 1'b0;

   always #5 clk = ~clk;

   spi_stream_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_tx_data  (tx_data),
      .i_tx_wr    (tx_wr),
      .o_tx_full  (tx_full),
      .o_tx_level (tx_level),
      .o_rx_data  (rx_data),
      .i_rx_rd    (rx_rd),
      .o_rx_empty (rx_empty),
      .o_tx_drop  (tx_drop),
      .o_m_start  (m_start),
      .i_m_busy   (m_busy),
      .o_m_dout   (m_dout),
      .i_m_din    (m_din)
   );

   // Behavioural master: latches DOUT on START, checks it against the
   // expected MOSI order, and answers with the inverted byte.
   always @(posedge clk) begin
      if (busy_cnt > 0) begin
         if (!hold_busy) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
               m_busy <= 1'b0;
               m_din  <= ~cur_dout;
            end
         end
      end else if (m_start) begin
         cur_dout  <= m_dout;
         m_busy    <= 1'b1;
         busy_cnt  <= BUSY_CYC;
         start_cnt <= start_cnt + 1;
         total++;
         if (exp_mosi.size() == 0) begin
            bad++;
            $display("FAIL mosi_unexpected got=%h exp=<none>", m_dout);
         end else begin
            e_mosi = exp_mosi.pop_front();
            if (m_dout !== e_mosi) begin
               bad++;
               $display("FAIL mosi_order got=%h exp=%h", m_dout, e_mosi);
            end
         end
      end
   end

   // DOUT must stay stable while the master is busy; START is one cycle wide.
   always @(negedge clk) begin
      if (mon_en && m_busy) begin
         total++;
         if (m_dout !== cur_dout) begin
            bad++;
            $display("FAIL dout_stable got=%h exp=%h", m_dout, cur_dout);
         end
      end
      if (m_start) begin
         total++;
         if (prev_start !== 1'b0) begin
            bad++;
            $display("FAIL start_width got=2+ cycles exp=1 cycle");
         end
      end
      prev_start = m_start;
   end

   task automatic reset_dut();
      rst     = 1'b1;
      tx_wr   = 1'b0;
      rx_rd   = 1'b0;
      tx_data = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push_exp(input logic [7:0] d);
      exp_mosi.push_back(d);
      exp_rx.push_back(~d);
   endtask

   task automatic wait_busy(input logic val, input int budget, input string name);
      int n = 0;
      while (m_busy !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (m_busy !== val) begin
         bad++;
         $display("FAIL %s timeout got=%b exp=%b", name, m_busy, val);
      end
   endtask

   task automatic wait_starts(input int target, input int budget, input string name);
      int n = 0;
      while (start_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (start_cnt < target) begin
         bad++;
         $display("FAIL %s timeout got=%0d exp=%0d", name, start_cnt, target);
      end
   endtask

   // Reads RX whenever it has data, comparing against the scoreboard.
   task automatic drain(input int budget, input string name);
      int         n = 0;
      logic [7:0] e;
      while (exp_rx.size() > 0 && n < budget) begin
         @(negedge clk);
         rx_rd = 1'b0;
         if (!rx_empty) begin
            e = exp_rx.pop_front();
            total++;
            if (rx_data !== e) begin
               bad++;
               $display("FAIL %s rx_data got=%h exp=%h", name, rx_data, e);
            end
            rx_rd = 1'b1;
         end
         n++;
      end
      @(negedge clk);
      rx_rd = 1'b0;
      total++;
      if (exp_rx.size() != 0) begin
         bad++;
         $display("FAIL %s drain_timeout got=%0d left exp=0", name, exp_rx.size());
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (tx_full !== 1'b0 || tx_level !== '0 || rx_empty !== 1'b1) begin
         bad++;
         $display("FAIL reset_fifo got=full%b lvl%0d empty%b exp=full0 lvl0 empty1",
                  tx_full, tx_level, rx_empty);
      end
      total++;
      if (m_start !== 1'b0 || m_dout !== 8'h00 || tx_drop !== 1'b0) begin
         bad++;
         $display("FAIL reset_outs got=start%b dout%h drop%b exp=start0 dout00 drop0",
                  m_start, m_dout, tx_drop);
      end
   endtask

   task automatic test_single();
      @(negedge clk);
      tx_data = 8'h56;
      tx_wr   = 1'b1;
      push_exp(8'h56);
      @(negedge clk);
      tx_wr = 1'b0;
      total++;
      if (tx_level !== 1 || m_start !== 1'b0) begin
         bad++;
         $display("FAIL single_write got=lvl%0d start%b exp=lvl1 start0", tx_level, m_start);
      end
      @(negedge clk);
      total++;
      if (m_start !== 1'b1 || m_dout !== 8'h56 || tx_level !== 0) begin
         bad++;
         $display("FAIL single_launch got=start%b dout%h lvl%0d exp=start1 dout56 lvl0",
                  m_start, m_dout, tx_level);
      end
      wait_busy(1'b1, 20, "single_busy_hi");
      wait_busy(1'b0, 20, "single_busy_lo");
      // Capture happens on the edge that sees BUSY low; visible after it.
      @(negedge clk);
      total++;
      if (rx_empty !== 1'b0 || rx_data !== 8'hA9) begin
         bad++;
         $display("FAIL single_rx got=empty%b data%h exp=empty0 dataa9", rx_empty, rx_data);
      end
      drain(50, "single");
      total++;
      if (rx_empty !== 1'b1 || tx_level !== 0) begin
         bad++;
         $display("FAIL single_end got=empty%b lvl%0d exp=empty1 lvl0", rx_empty, tx_level);
      end
   endtask

   task automatic test_burst();
      int s0 = start_cnt;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tx_data = 8'(i + 1);
         tx_wr   = 1'b1;
         push_exp(8'(i + 1));
      end
      @(negedge clk);
      tx_wr = 1'b0;
      drain(300, "burst");
      repeat (10) @(negedge clk);
      total++;
      if (start_cnt - s0 != 3 || exp_mosi.size() != 0) begin
         bad++;
         $display("FAIL burst_starts got=%0d exp=3", start_cnt - s0);
      end
   endtask

   task automatic test_overflow();
      int s0;
      logic exp_drop;
      hold_busy = 1'b1;
      @(negedge clk);
      tx_data = 8'hA0;
      tx_wr   = 1'b1;
      push_exp(8'hA0);
      @(negedge clk);
      tx_wr = 1'b0;
      wait_busy(1'b1, 20, "ovf_busy");
      s0 = start_cnt;
      for (int i = 0; i < DEPTH + 2; i++) begin
         @(negedge clk);
         if (i > 0) begin
            exp_drop = (i - 1 >= DEPTH);
            total++;
            if (tx_drop !== exp_drop) begin
               bad++;
               $display("FAIL ovf_drop[%0d] got=%b exp=%b", i - 1, tx_drop, exp_drop);
            end
         end
         tx_data = 8'(8'h10 + i);
         tx_wr   = 1'b1;
         if (i < DEPTH) push_exp(8'(8'h10 + i));
      end
      @(negedge clk);
      tx_wr = 1'b0;
      total++;
      if (tx_drop !== 1'b1 || tx_full !== 1'b1 || tx_level !== DEPTH) begin
         bad++;
         $display("FAIL ovf_full got=drop%b full%b lvl%0d exp=drop1 full1 lvl%0d",
                  tx_drop, tx_full, tx_level, DEPTH);
      end
      @(negedge clk);
      total++;
      if (tx_drop !== 1'b0) begin
         bad++;
         $display("FAIL ovf_drop_clear got=%b exp=0", tx_drop);
      end
      hold_busy = 1'b0;
      drain(600, "ovf");
      repeat (10) @(negedge clk);
      total++;
      if (start_cnt - s0 != DEPTH || exp_mosi.size() != 0 || tx_level !== 0) begin
         bad++;
         $display("FAIL ovf_starts got=%0d lvl%0d exp=%0d lvl0", start_cnt - s0, tx_level, DEPTH);
      end
   endtask

   // One RX pop while RX is full must release exactly one launch, one cycle
   // after the pop edge.
   task automatic release_one(input string name, input int exp_lvl);
      logic [7:0] e;
      @(negedge clk);
      e = exp_rx.pop_front();
      total++;
      if (rx_data !== e) begin
         bad++;
         $display("FAIL %s rx_head got=%h exp=%h", name, rx_data, e);
      end
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
      total++;
      if (m_start !== 1'b0) begin
         bad++;
         $display("FAIL %s early_start got=%b exp=0", name, m_start);
      end
      @(negedge clk);
      total++;
      if (m_start !== 1'b1 || tx_level !== exp_lvl) begin
         bad++;
         $display("FAIL %s resume got=start%b lvl%0d exp=start1 lvl%0d",
                  name, m_start, tx_level, exp_lvl);
      end
   endtask

   task automatic test_back_pressure();
      int s0 = start_cnt;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         tx_data = 8'(8'h80 + i);
         tx_wr   = 1'b1;
         push_exp(8'(8'h80 + i));
      end
      @(negedge clk);
      tx_wr = 1'b0;
      repeat (20) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tx_data = 8'(8'h90 + i);
         tx_wr   = 1'b1;
         push_exp(8'(8'h90 + i));
      end
      @(negedge clk);
      tx_wr = 1'b0;
      wait_starts(s0 + DEPTH, 400, "bp_fill");
      repeat (30) @(negedge clk);
      total++;
      if (start_cnt - s0 != DEPTH || tx_level !== 3 || m_start !== 1'b0 ||
          m_busy !== 1'b0 || rx_empty !== 1'b0) begin
         bad++;
         $display("FAIL bp_stall got=starts%0d lvl%0d start%b busy%b empty%b exp=starts%0d lvl3 start0 busy0 empty0",
                  start_cnt - s0, tx_level, m_start, m_busy, rx_empty, DEPTH);
      end
      release_one("bp_release", 2);
      repeat (30) @(negedge clk);
      total++;
      if (start_cnt - s0 != DEPTH + 1 || tx_level !== 2) begin
         bad++;
         $display("FAIL bp_one got=starts%0d lvl%0d exp=starts%0d lvl2",
                  start_cnt - s0, tx_level, DEPTH + 1);
      end
   endtask

   // Continues from the stalled back-pressure state (RX full, TX level 2).
   task automatic test_corners();
      logic [7:0] e;
      release_one("corner_prep", 1);
      repeat (30) @(negedge clk);
      // TX level 1 and stalled: free a slot, then write on the launch edge.
      @(negedge clk);
      e = exp_rx.pop_front();
      total++;
      if (rx_data !== e) begin
         bad++;
         $display("FAIL corner_head got=%h exp=%h", rx_data, e);
      end
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd   = 1'b0;
      tx_data = 8'hC3;
      tx_wr   = 1'b1;
      push_exp(8'hC3);
      @(negedge clk);
      tx_wr = 1'b0;
      total++;
      if (m_start !== 1'b1 || tx_level !== 1) begin
         bad++;
         $display("FAIL corner_pop_push got=start%b lvl%0d exp=start1 lvl1", m_start, tx_level);
      end
      drain(800, "corner");
      repeat (10) @(negedge clk);
      total++;
      if (rx_empty !== 1'b1 || tx_level !== 0 || exp_mosi.size() != 0) begin
         bad++;
         $display("FAIL corner_drained got=empty%b lvl%0d exp=empty1 lvl0", rx_empty, tx_level);
      end
      // Read on an empty RX FIFO must not disturb its count.
      @(negedge clk);
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
      total++;
      if (rx_empty !== 1'b1) begin
         bad++;
         $display("FAIL corner_rd_empty got=%b exp=1", rx_empty);
      end
      @(negedge clk);
      tx_data = 8'h3C;
      tx_wr   = 1'b1;
      push_exp(8'h3C);
      @(negedge clk);
      tx_wr = 1'b0;
      drain(100, "corner_after_empty_rd");
   endtask

   task automatic test_reset_mid();
      int s0;
      @(negedge clk);
      tx_data = 8'h5A;
      tx_wr   = 1'b1;
      exp_mosi.push_back(8'h5A);
      @(negedge clk);
      tx_data = 8'hA5;
      @(negedge clk);
      tx_wr = 1'b0;
      wait_busy(1'b1, 20, "mid_busy");
      @(negedge clk);
      mon_en = 1'b0;
      s0     = start_cnt;
      rst    = 1'b1;
      #2;
      total++;
      if (m_start !== 1'b0 || m_dout !== 8'h00 || rx_empty !== 1'b1 ||
          tx_level !== 0 || tx_full !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got=start%b dout%h empty%b lvl%0d full%b exp=start0 dout00 empty1 lvl0 full0",
                  m_start, m_dout, rx_empty, tx_level, tx_full);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_mosi.delete();
      exp_rx.delete();
      wait_busy(1'b0, 20, "mid_busy_lo");
      repeat (10) @(negedge clk);
      total++;
      if (rx_empty !== 1'b1 || start_cnt != s0) begin
         bad++;
         $display("FAIL mid_no_capture got=empty%b starts%0d exp=empty1 starts%0d",
                  rx_empty, start_cnt - s0, 0);
      end
      mon_en = 1'b1;
   endtask

   initial begin
      reset_dut();
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_back_pressure();
      test_corners();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_spi_stream_ctrl
